// File: rtl/macguffin_pkg.sv
// Shared definitions for the MacGuffin block packer: block geometry, packer
// states and the PKCS#7 tail-padding helper.
package macguffin_pkg;

  localparam int unsigned BLOCK_SIZE = 64;
  localparam int unsigned BYTES      = BLOCK_SIZE / 8;

  typedef enum logic [0:0] {S_FILL, S_PAD} packer_state_t;

  typedef logic [BLOCK_SIZE-1:0] block_t;

  // Slots k..BYTES-1 (big-endian byte order) take the pad value BYTES-k.
  function automatic block_t pad_block(input block_t acc, input logic [7:0] k);
    block_t     blk;
    logic [7:0] pad_val;
    blk     = acc;
    pad_val = 8'(BYTES) - k;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (8'(i) >= k) blk[BLOCK_SIZE-1-8*i -: 8] = pad_val;
    end
    return blk;
  endfunction

endpackage

// File: rtl/macguffin_block_packer.sv
// Packs a byte stream into big-endian cipher blocks with PKCS#7 padding and
// presents them through a single registered AXI4-Stream output stage.
module macguffin_block_packer
  import macguffin_pkg::*;
#(
  parameter int unsigned block_size = BLOCK_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [block_size-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam logic [7:0] LAST_SLOT = 8'(BYTES - 1);

  packer_state_t state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  block_t        acc_q, acc_d;
  block_t        tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;

  logic   out_free;
  logic   accept;
  block_t merged;
  block_t full_pad;

  assign out_free      = ~tvalid_q | m_axis_tready;
  assign s_axis_tready = ~rst & (state_q == S_FILL) & out_free;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign full_pad      = {BYTES{8'(BYTES)}};

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

  // Accumulator with the incoming byte dropped into slot cnt_q.
  always_comb begin
    merged = acc_q;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (cnt_q == 8'(i)) merged[BLOCK_SIZE-1-8*i -: 8] = s_axis_tdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q & ~m_axis_tready;
    tlast_d  = tlast_q;
    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          if (!s_axis_tlast && cnt_q != LAST_SLOT) begin
            acc_d = merged;
            cnt_d = cnt_q + 8'd1;
          end else begin
            tvalid_d = 1'b1;
            cnt_d    = 8'd0;
            acc_d    = '0;
            if (cnt_q == LAST_SLOT) begin
              tdata_d = merged;
              tlast_d = 1'b0;
              // An aligned message still owes a whole pad block.
              if (s_axis_tlast) state_d = S_PAD;
            end else begin
              tdata_d = pad_block(merged, cnt_q + 8'd1);
              tlast_d = 1'b1;
            end
          end
        end
      end
      S_PAD: begin
        if (out_free) begin
          tdata_d  = full_pad;
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          state_d  = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FILL;
      cnt_q    <= 8'd0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

endmodule
